// File: rtl/cc_regbank_pkg.sv
// Shared definitions for the general register bank write side and its read mux.
// The selection encoding and register count here must match the datapath read selector.
package cc_regbank_pkg;

    localparam int DATAWIDTH_MUX_SELECTION = 6;
    localparam int DATAWIDTH_BUS           = 32;
    localparam int NUM_REGS                = 38;
    localparam int REG_ZERO                = 0;
    localparam int ERRCNT_WIDTH            = 8;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } state_t;

endpackage

// File: rtl/cc_regbank_decoder.sv
// Turns a register selection into a one-hot load enable; the inverse of the read mux selection.
// Register zero is hardwired, so its enable bit never fires.
module cc_regbank_decoder
    import cc_regbank_pkg::*;
#(
    parameter int DATAWIDTH_MUX_SELECTION = cc_regbank_pkg::DATAWIDTH_MUX_SELECTION,
    parameter int NUM_REGS                = cc_regbank_pkg::NUM_REGS
) (
    input  logic [DATAWIDTH_MUX_SELECTION-1:0] sel,
    input  logic                               enable,
    output logic [NUM_REGS-1:0]                load_en,
    output logic                               out_of_range
);

    always_comb begin
        load_en      = '0;
        out_of_range = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (k != REG_ZERO && int'(sel) == k) begin
                load_en[k] = enable;
            end
        end
        if (int'(sel) >= NUM_REGS) begin
            out_of_range = enable;
        end
    end

endmodule

// File: rtl/cc_regbank_write_demux.sv
// Write side of the general register bank: valid/ready write port, one-deep write stage,
// clear sequencer and saturating out-of-range error counter; exports all registers as a flat bus.
module cc_regbank_write_demux
    import cc_regbank_pkg::*;
#(
    parameter int DATAWIDTH_MUX_SELECTION = cc_regbank_pkg::DATAWIDTH_MUX_SELECTION,
    parameter int DATAWIDTH_BUS           = cc_regbank_pkg::DATAWIDTH_BUS,
    parameter int NUM_REGS                = cc_regbank_pkg::NUM_REGS,
    parameter int ERRCNT_WIDTH            = cc_regbank_pkg::ERRCNT_WIDTH
) (
    input  logic                                CC_REGBANK_CLOCK_50,
    input  logic                                CC_REGBANK_RESET_InHigh,
    input  logic                                CC_WR_Valid_In,
    output logic                                CC_WR_Ready_Out,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0]  CC_WR_Selection_In,
    input  logic [DATAWIDTH_BUS-1:0]            CC_WR_DataBUS_In,
    input  logic                                CC_CLR_Start_In,
    output logic                                CC_CLR_Done_Out,
    output logic                                CC_WR_Error_Out,
    output logic [ERRCNT_WIDTH-1:0]             CC_WR_ErrCount_Out,
    output logic [NUM_REGS*DATAWIDTH_BUS-1:0]   CC_REGBANK_DataBUS_Out
);

    state_t state;
    state_t state_next;

    logic                               accept;
    logic                               stage_valid;
    logic [DATAWIDTH_MUX_SELECTION-1:0] stage_sel;
    logic [DATAWIDTH_BUS-1:0]           stage_data;
    logic [DATAWIDTH_MUX_SELECTION-1:0] clr_idx;
    logic                               clr_last;
    logic [NUM_REGS-1:0]                load_en;
    logic                               out_of_range;
    logic                               error_pulse;
    logic                               done_pulse;
    logic [ERRCNT_WIDTH-1:0]            err_count;
    logic [DATAWIDTH_BUS-1:0]           regs [NUM_REGS];

    assign accept   = CC_WR_Valid_In && CC_WR_Ready_Out;
    assign clr_last = (int'(clr_idx) == NUM_REGS - 1);

    always_ff @(posedge CC_REGBANK_CLOCK_50) begin
        if (CC_REGBANK_RESET_InHigh) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (CC_CLR_Start_In) state_next = DRAIN;
            DRAIN:   state_next = CLEAR;
            CLEAR:   if (clr_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ready comes from registered state only, so Valid never loops back into it.
    always_comb begin
        CC_WR_Ready_Out = (state == IDLE);
    end

    always_ff @(posedge CC_REGBANK_CLOCK_50) begin
        if (CC_REGBANK_RESET_InHigh) begin
            stage_valid <= 1'b0;
            stage_sel   <= '0;
            stage_data  <= '0;
        end else begin
            stage_valid <= accept;
            if (accept) begin
                stage_sel  <= CC_WR_Selection_In;
                stage_data <= CC_WR_DataBUS_In;
            end
        end
    end

    cc_regbank_decoder #(
        .DATAWIDTH_MUX_SELECTION (DATAWIDTH_MUX_SELECTION),
        .NUM_REGS                (NUM_REGS)
    ) u_decoder (
        .sel          (stage_sel),
        .enable       (stage_valid),
        .load_en      (load_en),
        .out_of_range (out_of_range)
    );

    // Terminal compare is checked before the increment, so the index stops at NUM_REGS-1.
    always_ff @(posedge CC_REGBANK_CLOCK_50) begin
        if (CC_REGBANK_RESET_InHigh) begin
            clr_idx <= '0;
        end else if (state == DRAIN) begin
            clr_idx <= DATAWIDTH_MUX_SELECTION'(1);
        end else if (state == CLEAR && !clr_last) begin
            clr_idx <= clr_idx + DATAWIDTH_MUX_SELECTION'(1);
        end
    end

    always_ff @(posedge CC_REGBANK_CLOCK_50) begin
        if (CC_REGBANK_RESET_InHigh) begin
            error_pulse <= 1'b0;
            done_pulse  <= 1'b0;
            err_count   <= '0;
        end else begin
            error_pulse <= out_of_range;
            done_pulse  <= (state == CLEAR) && clr_last;
            if (out_of_range && err_count != '1) begin
                err_count <= err_count + ERRCNT_WIDTH'(1);
            end
        end
    end

    assign CC_WR_Error_Out    = error_pulse;
    assign CC_CLR_Done_Out    = done_pulse;
    assign CC_WR_ErrCount_Out = err_count;

    // Register zero has no load enable and is never cleared to anything but zero.
    always_ff @(posedge CC_REGBANK_CLOCK_50) begin
        if (CC_REGBANK_RESET_InHigh) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (state == CLEAR && int'(clr_idx) == k) begin
                    regs[k] <= '0;
                end else if (load_en[k]) begin
                    regs[k] <= stage_data;
                end
            end
        end
    end

    always_comb begin
        CC_REGBANK_DataBUS_Out = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            CC_REGBANK_DataBUS_Out[k*DATAWIDTH_BUS +: DATAWIDTH_BUS] = regs[k];
        end
    end

endmodule

// File: tb/tb_cc_regbank_write_demux.sv
// Self-checking bench for cc_regbank_write_demux: directed vector table, multi-cycle
// sequences for back-to-back writes, saturation, clear and reset-during-clear, then random writes.
module tb_cc_regbank_write_demux;

    localparam int SW = 6;
    localparam int W  = 32;
    localparam int NR = 38;
    localparam int EW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          valid;
    logic          ready;
    logic [SW-1:0] sel;
    logic [W-1:0]  data;
    logic          start;
    logic          done;
    logic          error;
    logic [EW-1:0] err_count;
    logic [NR*W-1:0] bus;

    always #5 clock = ~clock;

    cc_regbank_write_demux dut (
        .CC_REGBANK_CLOCK_50     (clock),
        .CC_REGBANK_RESET_InHigh (reset),
        .CC_WR_Valid_In          (valid),
        .CC_WR_Ready_Out         (ready),
        .CC_WR_Selection_In      (sel),
        .CC_WR_DataBUS_In        (data),
        .CC_CLR_Start_In         (start),
        .CC_CLR_Done_Out         (done),
        .CC_WR_Error_Out         (error),
        .CC_WR_ErrCount_Out      (err_count),
        .CC_REGBANK_DataBUS_Out  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: register contents, error count, and the one write waiting to commit.
    logic [W-1:0] model_regs [NR];
    int           model_err_count;
    bit           model_idle;
    bit           pend_valid;
    int           pend_sel;
    logic [W-1:0] pend_data;
    bit           exp_error;

    typedef struct {
        int           sel;
        logic [W-1:0] data;
        bit           exp_err;
        logic [W-1:0] exp_slice;
    } vec_t;

    vec_t vectors [6];

    function automatic logic [W-1:0] slice(input int k);
        return bus[k*W +: W];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkBus(input string name);
        int first_bad;
        first_bad = -1;
        total++;
        for (int k = NR - 1; k >= 0; k--) begin
            if (slice(k) !== model_regs[k]) first_bad = k;
        end
        if (first_bad >= 0) begin
            bad++;
            $display("[TB] FAIL %s: slice %0d got %0h expected %0h", name, first_bad,
                     slice(first_bad), model_regs[first_bad]);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic modelReset();
        for (int k = 0; k < NR; k++) model_regs[k] = '0;
        model_err_count = 0;
        model_idle      = 1'b1;
        pend_valid      = 1'b0;
        pend_sel        = 0;
        pend_data       = '0;
        exp_error       = 1'b0;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        valid = 1'b0;
        start = 1'b0;
        tick();
        reset = 1'b0;
        modelReset();
    endtask

    // One clock cycle: drive inputs, take the edge, advance the model by the write rules.
    task automatic applyStimulus(input bit v, input int s, input logic [W-1:0] d, input bit st);
        bit accept_now;
        valid = v;
        sel   = SW'(s);
        data  = d;
        start = st;
        accept_now = v && model_idle;
        tick();
        exp_error = 1'b0;
        if (pend_valid) begin
            if (pend_sel >= 1 && pend_sel < NR) begin
                model_regs[pend_sel] = pend_data;
            end else if (pend_sel >= NR) begin
                exp_error = 1'b1;
                if (model_err_count < 255) model_err_count++;
            end
        end
        pend_valid = accept_now;
        pend_sel   = s;
        pend_data  = d;
        valid = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int busy;
        int done_seen;
        bit finished;

        reset = 1'b1;
        valid = 1'b0;
        start = 1'b0;
        sel   = '0;
        data  = '0;
        modelReset();

        vectors[0] = '{5,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        vectors[1] = '{0,  32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
        vectors[2] = '{38, 32'h1234_5678, 1'b1, 32'h0000_0000};
        vectors[3] = '{63, 32'hCAFE_F00D, 1'b1, 32'h0000_0000};
        vectors[4] = '{1,  32'h0000_0001, 1'b0, 32'h0000_0001};
        vectors[5] = '{37, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5};

        applyReset();
        applyReset();
        checkOutput("reset ready", ready, 1);
        checkOutput("reset done", done, 0);
        checkOutput("reset error", error, 0);
        checkOutput("reset errcount", err_count, 0);
        checkBus("reset bus");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, vectors[i].sel, vectors[i].data, 1'b0);
            checkOutput("vec ready", ready, 1);
            if (vectors[i].sel < NR) checkOutput("vec pre-commit slice", slice(vectors[i].sel), 0);
            applyStimulus(1'b0, 0, '0, 1'b0);
            checkOutput("vec error pulse", error, vectors[i].exp_err);
            checkOutput("vec errcount", err_count, model_err_count);
            if (vectors[i].sel < NR) checkOutput("vec slice", slice(vectors[i].sel), vectors[i].exp_slice);
            checkBus("vec bus");
            applyStimulus(1'b0, 0, '0, 1'b0);
            checkOutput("vec error cleared", error, 0);
        end
        checkOutput("errcount after two bad writes", err_count, 2);

        applyStimulus(1'b1, 3, 32'h11, 1'b0);
        applyStimulus(1'b1, 3, 32'h22, 1'b0);
        checkOutput("b2b first commit", slice(3), 32'h11);
        applyStimulus(1'b1, 37, 32'h33, 1'b0);
        checkOutput("b2b last wins", slice(3), 32'h22);
        applyStimulus(1'b0, 0, '0, 1'b0);
        checkOutput("b2b slice 37", slice(37), 32'h33);
        checkOutput("b2b no error", error, 0);
        checkBus("b2b bus");

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 38 + int'($urandom_range(0, 25)), $urandom, 1'b0);
            if (i == 5) checkOutput("sat error streaming", error, 1);
        end
        applyStimulus(1'b0, 0, '0, 1'b0);
        applyStimulus(1'b0, 0, '0, 1'b0);
        checkOutput("sat errcount", err_count, 255);
        checkOutput("sat error idle", error, 0);
        checkBus("sat bus unchanged");

        for (int k = 1; k < NR; k++) applyStimulus(1'b1, k, W'(k), 1'b0);
        applyStimulus(1'b0, 0, '0, 1'b0);
        applyStimulus(1'b0, 0, '0, 1'b0);
        checkBus("fill bus");

        applyStimulus(1'b1, 9, 32'hAA, 1'b1);
        model_idle = 1'b0;
        checkOutput("clr ready drop", ready, 0);
        busy = 1;
        done_seen = 0;
        finished = 1'b0;
        for (int i = 0; i < 60 && !finished; i++) begin
            applyStimulus(i == 5, 4, 32'h55, i == 6);
            if (i == 0) checkOutput("clr sel9 committed first", slice(9), 32'hAA);
            if (done) done_seen++;
            if (ready) begin
                finished = 1'b1;
                checkOutput("clr done with ready", done, 1);
            end else begin
                busy++;
            end
        end
        checkOutput("clr finished in bound", finished, 1);
        checkOutput("clr busy cycles", busy, 38);
        for (int k = 0; k < NR; k++) model_regs[k] = '0;
        model_idle = 1'b1;
        applyStimulus(1'b0, 0, '0, 1'b0);
        checkOutput("clr done single pulse", done_seen + int'(done), 1);
        checkOutput("clr errcount kept", err_count, 255);
        checkBus("clr bus zero");

        for (int k = 20; k < NR; k++) applyStimulus(1'b1, k, 32'hF0 + W'(k), 1'b0);
        applyStimulus(1'b0, 0, '0, 1'b0);
        applyStimulus(1'b0, 0, '0, 1'b0);
        applyStimulus(1'b0, 0, '0, 1'b1);
        model_idle = 1'b0;
        for (int i = 0; i < 11; i++) applyStimulus(1'b0, 0, '0, 1'b0);
        checkOutput("mid-clear ready", ready, 0);
        applyReset();
        checkOutput("rst-clear ready", ready, 1);
        checkOutput("rst-clear done", done, 0);
        checkOutput("rst-clear error", error, 0);
        checkOutput("rst-clear errcount", err_count, 0);
        checkBus("rst-clear bus");

        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), $urandom, 1'b0);
            checkOutput("rnd ready", ready, 1);
            checkOutput("rnd error", error, exp_error);
            checkOutput("rnd errcount", err_count, model_err_count);
            checkBus("rnd bus");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
